// File: rtl/imem_loader.sv
// Loads 16-bit instruction words from a framed byte stream (count, payload, XOR checksum)
// into instruction memory, holding the CPU while a load is running or has failed.
//
// state   | meaning
// IDLE    | no load since reset
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, then range check
// DATA_HI | waiting for instruction high byte
// DATA_LO | waiting for instruction low byte
// WRITE   | one-cycle memory write strobe
// CHECK   | waiting for checksum byte
// DONE    | load good, CPU released
// ERROR   | load failed, CPU held
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          ADDR_STEP = 1,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] STEP      = 16'(ADDR_STEP);
  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } stateT;

  stateT       state, stateNext;
  logic        byteReady;
  logic        xfer;
  logic        startAccept;
  logic        countTooBig;
  logic [7:0]  countHi;
  logic [15:0] wordCount;
  logic [15:0] wordIdx;
  logic [7:0]  csum;
  logic [7:0]  dataHi;
  logic [15:0] lenFull;

  assign lenFull     = {countHi, byte_data};
  assign countTooBig = {1'b0, lenFull} > MAX_COUNT;
  assign xfer        = byte_valid && byteReady;
  assign startAccept = start && (state == IDLE || state == DONE || state == ERROR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    byteReady = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) stateNext = LEN_HI;
      LEN_HI: begin
        byteReady = 1'b1;
        if (byte_valid) stateNext = LEN_LO;
      end
      LEN_LO: begin
        byteReady = 1'b1;
        if (byte_valid) begin
          if (countTooBig)         stateNext = ERROR;
          else if (lenFull == '0)  stateNext = CHECK;
          else                     stateNext = DATA_HI;
        end
      end
      DATA_HI: begin
        byteReady = 1'b1;
        if (byte_valid) stateNext = DATA_LO;
      end
      DATA_LO: begin
        byteReady = 1'b1;
        if (byte_valid) stateNext = WRITE;
      end
      WRITE: stateNext = (wordIdx + 16'd1 == wordCount) ? CHECK : DATA_HI;
      CHECK: begin
        byteReady = 1'b1;
        if (byte_valid) stateNext = (byte_data == csum) ? DONE : ERROR;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Address and data are registered with the strobe, so they already sit stable in WRITE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      countHi   <= '0;
      wordCount <= '0;
      wordIdx   <= '0;
      csum      <= '0;
      dataHi    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      err_code  <= 2'd0;
    end else begin
      mem_we <= 1'b0;
      if (startAccept) begin
        wordIdx  <= '0;
        csum     <= '0;
        err_code <= 2'd0;
      end
      if (xfer && state != CHECK) csum <= csum ^ byte_data;
      case (state)
        LEN_HI:  if (xfer) countHi <= byte_data;
        LEN_LO:  if (xfer) begin
          wordCount <= lenFull;
          if (countTooBig) err_code <= 2'd1;
        end
        DATA_HI: if (xfer) dataHi <= byte_data;
        DATA_LO: if (xfer) begin
          mem_we    <= 1'b1;
          mem_wdata <= {dataHi, byte_data};
          mem_addr  <= BASE_ADDR + wordIdx * STEP;
        end
        WRITE:   wordIdx <= wordIdx + 16'd1;
        CHECK:   if (xfer && byte_data != csum) err_code <= 2'd2;
        default: ;
      endcase
    end
  end

  assign byte_ready   = byteReady;
  assign cpu_hold     = !(state == IDLE || state == DONE);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign words_loaded = wordIdx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a second instance at BASE_ADDR FFFF sees the same stream.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [15:0] mem_addr, mem_wdata, words_loaded;
  logic [1:0]  err_code;
  logic        wByteReady, wMemWe, wCpuHold, wDone, wError;
  logic [15:0] wMemAddr, wMemWdata, wWordsLoaded;
  logic [1:0]  wErrCode;

  int checks = 0;
  int passed = 0;
  int wrCount = 0;
  int readyInWrite = 0;
  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];

  always #5 clock = ~clock;

  imem_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  imem_loader #(.BASE_ADDR(16'hFFFF), .ADDR_STEP(1), .MAX_WORDS(256)) dutWrap (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(wByteReady), .mem_we(wMemWe), .mem_addr(wMemAddr),
    .mem_wdata(wMemWdata), .cpu_hold(wCpuHold), .done(wDone), .error(wError),
    .err_code(wErrCode), .words_loaded(wWordsLoaded)
  );

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wrCount++;
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
      if (byte_ready !== 1'b0) readyInWrite++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Offers a byte and returns at the negedge after it was taken.
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      $display("FAIL send_timeout: byte %h not accepted after %0d cycles", b, guard);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b expected 0", byte_ready); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", mem_we); else passed++;
    checks++; if (mem_addr !== 16'h0000) $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); else passed++;
    checks++; if (wMemAddr !== 16'hFFFF) $display("FAIL rst_wrap_addr: got %h expected ffff", wMemAddr); else passed++;
    checks++; if ({cpu_hold, done, error, err_code} !== 5'b0) $display("FAIL rst_status: got %b expected 00000", {cpu_hold, done, error, err_code}); else passed++;
    checks++; if ({mem_wdata, words_loaded} !== 32'h0) $display("FAIL rst_data: got %h expected 0", {mem_wdata, words_loaded}); else passed++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_nominal();
    int base;
    base = wrCount;
    pulseStart();
    checks++; if (cpu_hold !== 1'b1) $display("FAIL nom_hold_on_start: got %b expected 1", cpu_hold); else passed++;
    sendByte(8'h00); sendByte(8'h02); sendByte(8'h12); sendByte(8'h34);
    checks++; if (mem_we !== 1'b1) $display("FAIL nom_we0_latency: got %b expected 1", mem_we); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 32'h0000_1234) $display("FAIL nom_write0: got %h expected 00001234", {mem_addr, mem_wdata}); else passed++;
    checks++; if (wMemAddr !== 16'hFFFF) $display("FAIL wrap_addr0: got %h expected ffff", wMemAddr); else passed++;
    sendByte(8'hAB); sendByte(8'hCD);
    checks++; if (mem_we !== 1'b1) $display("FAIL nom_we1_latency: got %b expected 1", mem_we); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 32'h0001_ABCD) $display("FAIL nom_write1: got %h expected 0001abcd", {mem_addr, mem_wdata}); else passed++;
    checks++; if (wMemAddr !== 16'h0000) $display("FAIL wrap_addr1: got %h expected 0000", wMemAddr); else passed++;
    sendByte(8'h42);
    checks++; if ({done, error, cpu_hold} !== 3'b100) $display("FAIL nom_status: got %b expected 100", {done, error, cpu_hold}); else passed++;
    checks++; if (words_loaded !== 16'd2) $display("FAIL nom_words: got %0d expected 2", words_loaded); else passed++;
    checks++; if (wrCount - base !== 2) $display("FAIL nom_write_count: got %0d expected 2", wrCount - base); else passed++;
    checks++; if (mem_addr !== 16'h0001 || mem_wdata !== 16'hABCD) $display("FAIL nom_hold_values: got %h %h expected 0001 abcd", mem_addr, mem_wdata); else passed++;
  endtask

  task automatic test_bad_checksum();
    int base;
    base = wrCount;
    pulseStart();
    checks++; if (done !== 1'b0) $display("FAIL bad_done_cleared: got %b expected 0", done); else passed++;
    sendByte(8'h00); sendByte(8'h02); sendByte(8'h12); sendByte(8'h34);
    sendByte(8'hAB); sendByte(8'hCD); sendByte(8'h43);
    checks++; if (wrCount - base !== 2) $display("FAIL bad_write_count: got %0d expected 2", wrCount - base); else passed++;
    checks++; if ({done, error, cpu_hold, err_code} !== 5'b01110) $display("FAIL bad_status: got %b expected 01110", {done, error, cpu_hold, err_code}); else passed++;
  endtask

  task automatic test_count_range();
    int base;
    base = wrCount;
    pulseStart();
    checks++; if ({error, err_code} !== 3'b000) $display("FAIL range_err_cleared: got %b expected 000", {error, err_code}); else passed++;
    sendByte(8'h01); sendByte(8'h01);
    checks++; if ({error, err_code, cpu_hold} !== 4'b1011) $display("FAIL range_257: got %b expected 1011", {error, err_code, cpu_hold}); else passed++;
    checks++; if (byte_ready !== 1'b0) $display("FAIL range_ready: got %b expected 0", byte_ready); else passed++;
    pulseStart();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    checks++; if ({done, error, err_code, cpu_hold} !== 5'b10000) $display("FAIL range_zero: got %b expected 10000", {done, error, err_code, cpu_hold}); else passed++;
    checks++; if (wrCount - base !== 0 || words_loaded !== 16'd0) $display("FAIL range_no_writes: got %0d/%0d expected 0/0", wrCount - base, words_loaded); else passed++;
  endtask

  task automatic test_gaps();
    logic [7:0] frame [0:8];
    frame = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h03};
    wrAddr.delete(); wrData.delete();
    readyInWrite = 0;
    pulseStart();
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      sendByte(frame[i]);
    end
    checks++; if ({done, error} !== 2'b10) $display("FAIL gap_status: got %b expected 10", {done, error}); else passed++;
    checks++; if (wrAddr.size() !== 3) $display("FAIL gap_write_count: got %0d expected 3", wrAddr.size());
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wrAddr[i] !== 16'(i) || wrData[i] !== {2{8'h11 * 8'(i + 1)}})
          $display("FAIL gap_write%0d: got %h %h expected %h %h", i, wrAddr[i], wrData[i], 16'(i), {2{8'h11 * 8'(i + 1)}});
        else passed++;
      end
    end
    checks++; if (readyInWrite !== 0) $display("FAIL gap_ready_in_write: got %0d expected 0", readyInWrite); else passed++;
  endtask

  task automatic test_reset_restart();
    int base;
    pulseStart();
    sendByte(8'h00); sendByte(8'h02); sendByte(8'h12); sendByte(8'h34); sendByte(8'hAB);
    byte_valid = 1'b1; byte_data = 8'hCD;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({byte_ready, mem_we, cpu_hold, done, error, err_code} !== 7'b0) $display("FAIL async_rst_ctrl: got %b expected 0000000", {byte_ready, mem_we, cpu_hold, done, error, err_code}); else passed++;
    checks++; if ({mem_addr, mem_wdata, words_loaded} !== 48'h0) $display("FAIL async_rst_data: got %h expected 0", {mem_addr, mem_wdata, words_loaded}); else passed++;
    base = wrCount;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    byte_valid = 1'b0;
    checks++; if (wrCount - base !== 0) $display("FAIL rst_no_write: got %0d expected 0", wrCount - base); else passed++;
    pulseStart();
    sendByte(8'h00);
    pulseStart();
    sendByte(8'h01); sendByte(8'h55); sendByte(8'h66);
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_5566}) $display("FAIL start_ignored_write: got %b %h %h expected 1 0000 5566", mem_we, mem_addr, mem_wdata); else passed++;
    sendByte(8'h32);
    checks++; if ({done, words_loaded} !== {1'b1, 16'd1}) $display("FAIL start_ignored_done: got %b %0d expected 1 1", done, words_loaded); else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_count_range();
    test_gaps();
    test_reset_restart();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
